// File: rtl/shift_arbiter.sv
// Two-requester front end for the shared 32-bit barrel shifter: arbitrate, issue, capture, return.
// Define SHIFT_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 always wins a tie.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_sh,
    input  logic [31:0] req0_rt,
    input  logic [31:0] req0_rs,
    input  logic        req0_RegImm,
    input  logic        req0_leftRight,
    input  logic        req0_AL,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_sh,
    input  logic [31:0] req1_rt,
    input  logic [31:0] req1_rs,
    input  logic        req1_RegImm,
    input  logic        req1_leftRight,
    input  logic        req1_AL,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,

    output logic [4:0]  sh_sh,
    output logic [31:0] sh_rt,
    output logic [31:0] sh_rs,
    output logic        sh_RegImm,
    output logic        sh_leftRight,
    output logic        sh_AL,
    input  logic [31:0] sh_out
);

    typedef struct packed {
        logic [4:0]  sh;
        logic [31:0] rt;
        logic [31:0] rs;
        logic        reg_imm;
        logic        left_right;
        logic        al;
    } op_t;

    logic [1:0]  req_valid_v;
    logic [1:0]  req_ready_v;
    logic [1:0]  rsp_ready_v;
    logic [1:0]  rsp_valid_v;
    op_t         req_op [2];

    logic        iss_valid_q, iss_valid_d;
    logic        iss_id_q,    iss_id_d;
    op_t         iss_op_q,    iss_op_d;

    logic        res_valid_q, res_valid_d;
    logic        res_id_q,    res_id_d;
    logic [31:0] res_data_q,  res_data_d;

    logic        winner;
    logic        tie_winner;
    logic        accept;
    logic        res_take;
    logic        res_done;
    logic        iss_free;

    assign req_valid_v = {req1_valid, req0_valid};
    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    assign req_op[0] = {req0_sh, req0_rt, req0_rs, req0_RegImm, req0_leftRight, req0_AL};
    assign req_op[1] = {req1_sh, req1_rt, req1_rs, req1_RegImm, req1_leftRight, req1_AL};

    // The result register frees up in the same edge its owner consumes it, so a full pipe still streams.
    assign res_done = res_valid_q && rsp_ready_v[res_id_q];
    assign res_take = iss_valid_q && (!res_valid_q || rsp_ready_v[res_id_q]);
    assign iss_free = !iss_valid_q || res_take;

`ifdef SHIFT_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ~winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign tie_winner = ptr_q;
`else
    assign tie_winner = 1'b0;
`endif

    always_comb begin
        winner = 1'b0;
        if (req_valid_v == 2'b11) begin
            winner = tie_winner;
        end else if (req_valid_v[1]) begin
            winner = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_v[gi] = rst_n && iss_free && (winner == 1'(gi));
            assign rsp_valid_v[gi] = res_valid_q && (res_id_q == 1'(gi));
        end
    endgenerate

    assign accept = |(req_valid_v & req_ready_v);

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_id_d    = iss_id_q;
        iss_op_d    = iss_op_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_id_d    = winner;
            iss_op_d    = req_op[winner];
        end else if (res_take) begin
            iss_valid_d = 1'b0;
        end
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (res_take) begin
            res_valid_d = 1'b1;
            res_id_d    = iss_id_q;
            res_data_d  = sh_out;
        end else if (res_done) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_data_q  <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_op_q    <= iss_op_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign req0_ready   = req_ready_v[0];
    assign req1_ready   = req_ready_v[1];
    assign rsp0_valid   = rsp_valid_v[0];
    assign rsp1_valid   = rsp_valid_v[1];
    assign rsp0_data    = res_data_q;
    assign rsp1_data    = res_data_q;

    assign sh_sh        = iss_op_q.sh;
    assign sh_rt        = iss_op_q.rt;
    assign sh_rs        = iss_op_q.rs;
    assign sh_RegImm    = iss_op_q.reg_imm;
    assign sh_leftRight = iss_op_q.left_right;
    assign sh_AL        = iss_op_q.al;

endmodule
